// File: rtl/pi_code_ctrl.sv
// Bang-bang CDR loop controller: decimates PD votes, applies P + saturating I steps to a wrapping PI code.
// Optional override (ovr_en/ovr_code) is built when PI_CODE_OVR_EN is defined.
module pi_code_ctrl #(
  parameter int CODE_W    = 11,
  parameter int DEC_LEN   = 8,
  parameter int KP_ACQ    = 8,
  parameter int KP_TRK    = 1,
  parameter int FREQ_W    = 12,
  parameter int FSHIFT    = 4,
  parameter int ACQ_DEC   = 64,
  parameter int INIT_CODE = 0
) (
  input  logic              CLK,
  input  logic              rst_n,
  input  logic              pd_valid,
  input  logic              up,
  input  logic              dn,
  input  logic              hold,
  input  logic              restart,
`ifdef PI_CODE_OVR_EN
  input  logic              ovr_en,
  input  logic [CODE_W-1:0] ovr_code,
`endif
  output logic [CODE_W-1:0] pi_code,
  output logic              code_upd,
  output logic              locked
);

  localparam int WW = $clog2(DEC_LEN);
  localparam int NW = WW + 2;
  localparam int AW = $clog2(ACQ_DEC + 1);
  localparam logic [WW-1:0]            WIN_LAST = WW'(DEC_LEN - 1);
  localparam logic [AW-1:0]            ACQ_LAST = AW'(ACQ_DEC - 1);
  localparam logic [CODE_W-1:0]        KP_ACQ_C = CODE_W'(KP_ACQ);
  localparam logic [CODE_W-1:0]        KP_TRK_C = CODE_W'(KP_TRK);
  localparam logic signed [FREQ_W-1:0] FREQ_MAX = {1'b0, {(FREQ_W-1){1'b1}}};
  localparam logic signed [FREQ_W-1:0] FREQ_MIN = {1'b1, {(FREQ_W-2){1'b0}}, 1'b1};

  typedef enum logic [1:0] {ACQ, TRACK, HOLD} state_t;

  state_t                   state, state_nxt, held_state, held_nxt;
  logic [WW-1:0]            win_cnt;
  logic signed [NW-1:0]     net, net_sum;
  logic [1:0]               vote, dir, dir_new;
  logic                     dec_pending, freeze, apply;
  logic [AW-1:0]            acq_cnt;
  logic signed [FREQ_W-1:0] freq;
  logic [CODE_W-1:0]        kp_sel, kp_term, int_term;

`ifdef PI_CODE_OVR_EN
  assign freeze = hold | ovr_en;
`else
  assign freeze = hold;
`endif

  // A pending decision is dropped rather than applied if the loop is restarted or frozen that cycle.
  assign apply = dec_pending & ~restart & ~freeze;

  // dir/vote use 2'b01 = +1, 2'b11 = -1, 2'b00 = 0
  always_comb begin
    vote = 2'b00;
    if (up && !dn)
      vote = 2'b01;
    else if (dn && !up)
      vote = 2'b11;
    net_sum = net + {{(NW-2){vote[1]}}, vote};
    dir_new = 2'b00;
    if (net_sum[NW-1])
      dir_new = 2'b11;
    else if (net_sum != '0)
      dir_new = 2'b01;

    kp_sel  = (state == TRACK) ? KP_TRK_C : KP_ACQ_C;
    kp_term = '0;
    if (dir == 2'b01)
      kp_term = kp_sel;
    else if (dir == 2'b11)
      kp_term = -kp_sel;
    int_term = '0;
    if (state == TRACK)
      int_term = CODE_W'(int'(freq) >>> FSHIFT);
  end

  always_comb begin
    state_nxt = state;
    held_nxt  = held_state;
    if (restart) begin
      state_nxt = ACQ;
    end else if (hold) begin
      state_nxt = HOLD;
      if (state != HOLD)
        held_nxt = state;
    end else if (state == HOLD) begin
      state_nxt = held_state;
    end else if (state == ACQ && apply && acq_cnt == ACQ_LAST) begin
      state_nxt = TRACK;
    end
    locked = (state == TRACK) || (state == HOLD && held_state == TRACK);
  end

  always_ff @(posedge CLK or negedge rst_n) begin
    if (!rst_n) begin
      state      <= ACQ;
      held_state <= ACQ;
    end else begin
      state      <= state_nxt;
      held_state <= held_nxt;
    end
  end

  always_ff @(posedge CLK or negedge rst_n) begin
    if (!rst_n) begin
      pi_code     <= CODE_W'(INIT_CODE);
      code_upd    <= 1'b0;
      win_cnt     <= '0;
      net         <= '0;
      dir         <= 2'b00;
      dec_pending <= 1'b0;
      acq_cnt     <= '0;
      freq        <= '0;
    end else begin
      code_upd    <= 1'b0;
      dec_pending <= 1'b0;
      if (restart || freeze) begin
        win_cnt <= '0;
        net     <= '0;
        if (restart) begin
          freq    <= '0;
          acq_cnt <= '0;
        end
      end else begin
        if (pd_valid) begin
          if (win_cnt == WIN_LAST) begin
            win_cnt     <= '0;
            net         <= '0;
            dir         <= dir_new;
            dec_pending <= 1'b1;
          end else begin
            win_cnt <= win_cnt + WW'(1);
            net     <= net_sum;
          end
        end
        if (dec_pending) begin
          pi_code  <= pi_code + kp_term + int_term;
          code_upd <= 1'b1;
          if (state == TRACK) begin
            if (dir == 2'b01 && freq != FREQ_MAX)
              freq <= freq + FREQ_W'(1);
            else if (dir == 2'b11 && freq != FREQ_MIN)
              freq <= freq - FREQ_W'(1);
          end else begin
            freq    <= '0;
            acq_cnt <= acq_cnt + AW'(1);
          end
        end
      end
`ifdef PI_CODE_OVR_EN
      if (ovr_en) begin
        pi_code  <= ovr_code;
        code_upd <= (ovr_code != pi_code);
      end
`endif
    end
  end

endmodule
